alu_exec: RTL and testbench
===========================

# alu_exec

Execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder, together with two operands, and returns a registered result with flags. It sits between the decoder/register-read stage and the writeback/branch logic. A valid/ready handshake on both sides allows an optional iterative multiply to stall the datapath.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation request present
- in_ready  output  1  unit accepts a request this cycle
- alu_control  input  4  operation code
- a  input  WIDTH  operand A (rs)
- b  input  WIDTH  operand B (rt or immediate)
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer takes result this cycle
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- overflow  output  1  signed overflow (ADD/SUB only)
- illegal  output  1  unrecognised alu_control code

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed; result = {0…, a<b}), 1100 NOR, 1000 MUL (only with macro). Any other code is illegal: result 0, zero 1, overflow 0, illegal 1.
- Handshake: a request is accepted on a cycle where in_valid && in_ready. Output is transferred on a cycle where out_valid && out_ready.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. Accept a single-cycle op → HOLD. Accept MUL → BUSY.
  - BUSY: in_ready=0, out_valid=0. Iterate the multiply. On the final iteration → HOLD.
  - HOLD: out_valid=1. If out_ready=0, stay in HOLD with result and flags frozen. If out_ready=1 and in_valid=1, accept the new request in the same cycle (in_ready = out_ready); go to HOLD for a single-cycle op or to BUSY for MUL. If out_ready=1 and in_valid=0, go to IDLE.
- Overflow:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from a.
  - All other ops: 0.
- Arithmetic wraps modulo 2^WIDTH. MUL returns the low WIDTH bits of the unsigned product (equal to the low bits of the signed product); overflow=0.
- Operands are captured at acceptance. Changes to a, b, or alu_control afterwards have no effect.
- Reset:
  - State → IDLE; result, zero, overflow, illegal, out_valid → 0.
  - in_ready=0 while reset is high.
  - A multiply in progress is discarded; no output is produced for it.

## Timing
- Single-cycle ops: request accepted at edge N; out_valid=1 and result visible after edge N+1 (1-cycle latency). Back-to-back throughput is 1 op/cycle while out_ready=1.
- MUL: accepted at edge N; BUSY for exactly WIDTH cycles (one shift-add per cycle, iteration counter from WIDTH-1 down to 0); out_valid=1 after edge N+WIDTH+1.
- zero is derived from the registered result and updates in the same cycle as result.
- No combinational path from in_valid, a, b, or alu_control to any output. in_ready depends combinationally only on state and out_ready.

## Configuration
- ALU_EXEC_MUL_EN defined:
  - Code 1000 performs the iterative MUL.
  - BUSY state and multiplier datapath are present.
- ALU_EXEC_MUL_EN undefined:
  - Code 1000 is illegal and completes in 1 cycle with illegal=1.
  - BUSY state is unreachable and the multiplier datapath is removed.
  - in_ready is never deasserted except during reset or HOLD with out_ready=0.

## Structure
- alu_pkg: alu_ctrl_t enum of the 4-bit codes (shared with the ALU control decoder), alu_exec_state_t enum (IDLE/BUSY/HOLD), WIDTH default constant.
- Sub-module alu_mul_iter: start/done pulse interface, radix-2 shift-add multiplier with accumulator, multiplicand, multiplier and counter registers. Instantiated only under ALU_EXEC_MUL_EN.

## Test plan
- ADD a=0x7FFFFFFF, b=1, out_ready=1 → one cycle later: result 0x80000000, overflow 1, zero 0, illegal 0.
- SUB a=5, b=5, then SLT a=0xFFFFFFFF, b=1 issued back-to-back → result 0 with zero 1 on cycle 1, then result 1 on cycle 2; in_ready held at 1 throughout.
- NOR a=0, b=0x0000FFFF with out_ready=0 for 3 cycles → result 0xFFFF0000 held stable with out_valid=1 and in_ready=0; released on the cycle out_ready rises.
- MUL a=0xFFFFFFFF, b=3 (macro on) → in_ready=0 for 32 cycles; result 0xFFFFFFFD, overflow 0. With the macro off → 1-cycle response, illegal 1, result 0.
- Code 0011 → illegal 1, zero 1, result 0.
- Reset asserted mid-MUL (cycle 10 of BUSY) → next cycle out_valid 0, all outputs 0, state IDLE; no stale result appears after reset is released.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, execution FSM states, default datapath width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: alu_ctrl_t (4-bit ALU control codes, also used by the ALU control decoder),
//           alu_exec_state_t (IDLE/BUSY/HOLD), ALU_WIDTH (default operand width).
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_MUL = 4'b1000,
        ALU_NOR = 4'b1100
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } alu_exec_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier returning the low WIDTH bits of the unsigned product.
// Latency: start at edge N, done high during the cycle before edge N+WIDTH, product valid with done.
// Backpressure: none; the caller must consume product in the done cycle.
// Ports: clk, reset (sync, active-high), start (loads a/b), a, b, done (final iteration), product.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q,   busy_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] addend;

    assign addend  = mplier_q[0] ? mcand_q : '0;
    // Product includes the addend of the current (possibly final) iteration.
    assign product = acc_q + addend;
    assign done    = busy_q && (cnt_q == '0);

    always_comb begin
        busy_d   = busy_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            busy_d   = 1'b1;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = CW'(WIDTH - 1);
        end else if (busy_q) begin
            acc_d    = acc_q + addend;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execution unit: AND/OR/ADD/SUB/SLT/NOR, optional iterative MUL (macro ALU_EXEC_MUL_EN).
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL; back-to-back 1 op/cycle.
// Backpressure: result held in HOLD while out_ready=0; in_ready = out_ready in HOLD, 0 in BUSY/reset.
// Ports: clk, reset (sync, active-high), in_valid/in_ready, alu_control, a, b,
//        out_valid/out_ready, result, zero, overflow, illegal.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    alu_exec_state_t  state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;

    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf, alu_ill;

    assign in_ready  = !reset && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_HOLD);
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

`ifdef ALU_EXEC_MUL_EN
    assign is_mul = (alu_control == ALU_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    // Without the multiplier, code 1000 falls through to the illegal path.
    assign is_mul      = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    assign mul_start = accept && is_mul;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (alu_control)
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            ALU_NOR: alu_res = ~(a | b);
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT: alu_res = WIDTH'($signed(a) < $signed(b));
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d  = ST_HOLD;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        ill_d    = alu_ill;
                    end
                end else if ((state_q == ST_HOLD) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d  = ST_HOLD;
                    result_d = mul_product;
                    zero_d   = (mul_product == '0);
                    ovf_d    = 1'b0;
                    ill_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec (default WIDTH=32).
// Latency: n/a.
// Backpressure: exercises out_ready stalls and back-to-back acceptance.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero, overflow, illegal;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_exec #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow),
        .illegal     (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] ctl, input logic [31:0] va, input logic [31:0] vb);
        in_valid    = 1'b1;
        alu_control = ctl;
        a           = va;
        b           = vb;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] r, input logic z,
                           input logic o, input logic il);
        chk({tag, ".vld"},  {31'd0, out_valid}, 32'd1);
        chk({tag, ".res"},  result, r);
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
        chk({tag, ".ovf"},  {31'd0, overflow}, {31'd0, o});
        chk({tag, ".ill"},  {31'd0, illegal}, {31'd0, il});
    endtask

    initial begin
        int cyc;
        int stale;
        reset = 1'b1; in_valid = 1'b0; alu_control = 4'h0; a = '0; b = '0; out_ready = 1'b1;
        step(); step();
        chk("rst.in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.result",    result, 32'd0);
        chk("rst.flags",     {29'd0, zero, overflow, illegal}, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle.in_ready", {31'd0, in_ready}, 32'd1);

        // ADD overflow
        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        step(); in_valid = 1'b0;
        chk_out("add", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        step();
        chk("add.drain", {31'd0, out_valid}, 32'd0);

        // SUB then SLT back to back
        issue(4'b0110, 32'd5, 32'd5);
        step();
        chk_out("sub", 32'd0, 1'b1, 1'b0, 1'b0);
        chk("sub.in_ready", {31'd0, in_ready}, 32'd1);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
        step(); in_valid = 1'b0;
        chk_out("slt", 32'd1, 1'b0, 1'b0, 1'b0);
        chk("slt.in_ready", {31'd0, in_ready}, 32'd1);
        step();

        // AND / OR / SUB overflow back to back
        issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        step();
        chk_out("and", 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        issue(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00);
        step();
        chk_out("or", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
        issue(4'b0110, 32'h8000_0000, 32'h0000_0001);
        step(); in_valid = 1'b0;
        chk_out("subovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        step();

        // NOR with output stall; operands changed after acceptance
        out_ready = 1'b0;
        issue(4'b1100, 32'h0000_0000, 32'h0000_FFFF);
        step();
        in_valid = 1'b1; alu_control = 4'b0010; a = 32'h1234_5678; b = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("nor.hold%0d", i), 32'hFFFF_0000, 1'b0, 1'b0, 1'b0);
            chk($sformatf("nor.in_ready%0d", i), {31'd0, in_ready}, 32'd0);
            if (i < 2) step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("nor.release_rdy", {31'd0, in_ready}, 32'd1);
        step();
        chk("nor.drain", {31'd0, out_valid}, 32'd0);

        // Illegal code
        issue(4'b0011, 32'hDEAD_BEEF, 32'h1234_5678);
        step(); in_valid = 1'b0;
        chk_out("ill", 32'd0, 1'b1, 1'b0, 1'b1);
        step();

        // MUL
        issue(4'b1000, 32'hFFFF_FFFF, 32'd3);
        step(); in_valid = 1'b0; a = 32'h0; b = 32'h0;
`ifdef ALU_EXEC_MUL_EN
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            chk($sformatf("mul.busy%0d", cyc), {31'd0, in_ready}, 32'd0);
            cyc++;
            step();
        end
        chk("mul.cycles", cyc, 32'd32);
        chk_out("mul", 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
`else
        chk_out("mul_off", 32'd0, 1'b1, 1'b0, 1'b1);
`endif
        step();
        chk("mul.drain", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of work: leave a nonzero result behind first
        issue(4'b0001, 32'hAAAA_0000, 32'h0000_5555);
        step();
        chk_out("pre_rst", 32'hAAAA_5555, 1'b0, 1'b0, 1'b0);
`ifdef ALU_EXEC_MUL_EN
        issue(4'b1000, 32'hFFFF_FFFF, 32'd3);
        step(); in_valid = 1'b0;
        repeat (9) step();
`else
        out_ready = 1'b0;
        issue(4'b0010, 32'd1, 32'd2);
        step(); in_valid = 1'b0;
`endif
        reset = 1'b1;
        step();
        chk("mrst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst.result",    result, 32'd0);
        chk("mrst.flags",     {29'd0, zero, overflow, illegal}, 32'd0);
        chk("mrst.in_ready",  {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mrst.idle_rdy", {31'd0, in_ready}, 32'd1);
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid !== 1'b0) stale++;
        end
        chk("mrst.no_stale", stale, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
